// File: rtl/snow64_pipelined_simd_shifter_pkg.sv
// PkgSnow64Shifter: shared op/size encodings, level count and stage control payload
// for the pipelined SIMD shifter.
package PkgSnow64Shifter;
    localparam int LOG2__WIDTH = 6;

    typedef enum logic [1:0] {LSL = 2'd0, LSR = 2'd1, ASR = 2'd2, OP_RSVD = 2'd3} ShiftOp;
    typedef enum logic [1:0] {SIZE_8 = 2'd0, SIZE_16 = 2'd1, SIZE_32 = 2'd2, SIZE_64 = 2'd3} LaneSize;

    // Data, per-byte amounts, overflow and sign masks are width-dependent and live beside this.
    typedef struct packed {
        ShiftOp  op;
        LaneSize size;
    } StageCtrl;

    function automatic int LANE_WIDTH(input LaneSize size);
        return 8 << size;
    endfunction
endpackage

// File: rtl/snow64_pipelined_simd_shifter_level.sv
// snow64_simd_shift_level: one combinational 2^LEVEL shift step applied lane-wise.
// in_en / in_sign are per byte, replicated across each lane.
module snow64_simd_shift_level
    import PkgSnow64Shifter::*;
#(
    parameter int WIDTH = 64,
    parameter int LEVEL = 0
) (
    input  ShiftOp             in_op,
    input  LaneSize            in_size,
    input  logic [WIDTH/8-1:0] in_en,
    input  logic [WIDTH/8-1:0] in_sign,
    input  logic [WIDTH-1:0]   in_data,
    output logic [WIDTH-1:0]   out_data
);
    localparam int S = 1 << LEVEL;

    int   lw, pos;
    logic act, right;

    always_comb begin
        lw = LANE_WIDTH(in_size);
        act = S < lw;
        right = in_op == LSR || in_op == ASR;
        out_data = in_data;
        for (int i = 0; i < WIDTH; i++) begin
            pos = i & (lw - 1);
            if (act && in_en[i / 8])
                out_data[i] = right ? ((pos + S < lw) ? in_data[(i + S) % WIDTH] : (in_op == ASR && in_sign[i / 8]))
                                    : ((pos >= S) ? in_data[(i + WIDTH - S) % WIDTH] : 1'b0);
        end
    end
endmodule

// File: rtl/snow64_pipelined_simd_shifter.sv
// snow64_pipelined_simd_shifter: LSL/LSR/ASR on 8/16/32/64-bit lanes, six shift levels
// spread over NUM_PIPE_STAGES registered stages with valid/ready flow control.
module snow64_pipelined_simd_shifter
    import PkgSnow64Shifter::*;
#(
    parameter int WIDTH__DATA_INOUT = 64,
    parameter int NUM_PIPE_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_flush,
    input  logic                         in_req_valid,
    output logic                         out_req_ready,
    input  logic [1:0]                   in_op,
    input  logic [1:0]                   in_size,
    input  logic [WIDTH__DATA_INOUT-1:0] in_to_shift,
    input  logic [WIDTH__DATA_INOUT-1:0] in_amount,
    output logic                         out_res_valid,
    input  logic                         in_res_ready,
    output logic [WIDTH__DATA_INOUT-1:0] out_data
);
    localparam int W = WIDTH__DATA_INOUT;
    localparam int NS = NUM_PIPE_STAGES;
    localparam int NB = W / 8;
    localparam int LPS = LOG2__WIDTH / NS;

    logic [NS-1:0]               vld_q, vld_d, ld;
    logic [NS-1:0][W-1:0]        data_q, data_d;
    logic [NS-1:0][NB-1:0][5:0]  amt_q, amt_d;
    logic [NS-1:0][NB-1:0]       ovf_q, ovf_d, sgn_q, sgn_d;
    StageCtrl [NS-1:0]           ctl_q, ctl_d;

    logic                 src_vld [NS];
    logic [W-1:0]         src_data [NS];
    logic [NB-1:0][5:0]   src_amt [NS];
    logic [NB-1:0]        src_ovf [NS], src_sgn [NS];
    StageCtrl             src_ctl [NS];
    logic [W-1:0]         lvl_in [LOG2__WIDTH], lvl_out [LOG2__WIDTH];

    logic [NB-1:0][5:0]   s0_amt;
    logic [NB-1:0]        s0_ovf, s0_sgn, hb;
    StageCtrl             s0_ctl;
    int                   lw, nb, base;

    // Per byte: the owning lane's low amount bits, sign, and whether amount >= lane width.
    always_comb begin
        lw = LANE_WIDTH(LaneSize'(in_size));
        nb = lw / 8;
        s0_ctl.op = ShiftOp'(in_op);
        s0_ctl.size = LaneSize'(in_size);
        hb = '0;
        for (int j = 0; j < W; j++)
            if ((j & (lw - 1)) >= 3 + int'(in_size)) hb[j / 8] = hb[j / 8] | in_amount[j];
        for (int b = 0; b < NB; b++) begin
            base = b & ~(nb - 1);
            s0_sgn[b] = in_to_shift[(base + nb) * 8 - 1];
            s0_amt[b] = in_amount[base * 8 +: 6];
            s0_ovf[b] = 1'b0;
            for (int c = 0; c < NB; c++)
                if ((c & ~(nb - 1)) == base) s0_ovf[b] = s0_ovf[b] | hb[c];
        end
    end

    always_comb begin
        ld[NS-1] = !vld_q[NS-1] || in_res_ready;
        for (int s = NS - 2; s >= 0; s--) ld[s] = !vld_q[s] || ld[s + 1];
    end

    assign out_req_ready = !in_flush && ld[0];
    assign out_res_valid = vld_q[NS-1];
    assign out_data = data_q[NS-1];

    for (genvar s = 0; s < NS; s++) begin : g_src
        if (s == 0) begin : g_in
            assign src_vld[s] = in_req_valid && out_req_ready;
            assign src_data[s] = in_to_shift;
            assign src_amt[s] = s0_amt;
            assign src_ovf[s] = s0_ovf;
            assign src_sgn[s] = s0_sgn;
            assign src_ctl[s] = s0_ctl;
        end else begin : g_reg
            assign src_vld[s] = vld_q[s - 1];
            assign src_data[s] = data_q[s - 1];
            assign src_amt[s] = amt_q[s - 1];
            assign src_ovf[s] = ovf_q[s - 1];
            assign src_sgn[s] = sgn_q[s - 1];
            assign src_ctl[s] = ctl_q[s - 1];
        end
    end

    for (genvar k = 0; k < LOG2__WIDTH; k++) begin : g_lvl
        localparam int S = k / LPS;
        logic [NB-1:0] en;
        always_comb for (int b = 0; b < NB; b++) en[b] = src_amt[S][b][k];
        if (k % LPS == 0) begin : g_head
            assign lvl_in[k] = src_data[S];
        end else begin : g_next
            assign lvl_in[k] = lvl_out[k - 1];
        end
        snow64_simd_shift_level #(.WIDTH(W), .LEVEL(k)) u_level (
            .in_op   (src_ctl[S].op),
            .in_size (src_ctl[S].size),
            .in_en   (en),
            .in_sign (src_sgn[S]),
            .in_data (lvl_in[k]),
            .out_data(lvl_out[k])
        );
    end

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            vld_d[s] = !in_flush && (ld[s] ? src_vld[s] : vld_q[s]);
            data_d[s] = ld[s] ? lvl_out[(s + 1) * LPS - 1] : data_q[s];
            amt_d[s] = ld[s] ? src_amt[s] : amt_q[s];
            ovf_d[s] = ld[s] ? src_ovf[s] : ovf_q[s];
            sgn_d[s] = ld[s] ? src_sgn[s] : sgn_q[s];
            ctl_d[s] = ld[s] ? src_ctl[s] : ctl_q[s];
        end
        // Overflowed lanes are replaced wholesale as they enter the last stage.
        for (int b = 0; b < NB; b++)
            if (ld[NS-1] && src_ovf[NS-1][b])
                data_d[NS-1][b * 8 +: 8] = {8{src_ctl[NS-1].op == ASR && src_sgn[NS-1][b]}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            data_q <= '0;
            amt_q <= '0;
            ovf_q <= '0;
            sgn_q <= '0;
            ctl_q <= '0;
        end else begin
            vld_q <= vld_d;
            data_q <= data_d;
            amt_q <= amt_d;
            ovf_q <= ovf_d;
            sgn_q <= sgn_d;
            ctl_q <= ctl_d;
        end
    end
endmodule

// File: tb/tb_snow64_pipelined_simd_shifter.sv
// tb_snow64_pipelined_simd_shifter: directed vectors into a scoreboard queue, a negedge
// monitor pops on every consumed result; flow-control cases checked inline.
module tb_snow64_pipelined_simd_shifter;
    localparam int W = 64;
    localparam int NS = 2;

    logic clk = 0, rst = 1, in_flush = 0, in_req_valid = 0, in_res_ready = 1;
    logic out_req_ready, out_res_valid;
    logic [1:0] in_op = 0, in_size = 0;
    logic [W-1:0] in_to_shift = 0, in_amount = 0, out_data, held;
    logic [W-1:0] exp_q [$];
    int n_vec = 0, n_fail = 0;

    typedef struct {
        logic [1:0]   op, sz;
        logic [W-1:0] a, b, e;
    } vec_t;
    vec_t vecs [$];
    logic [W-1:0] bp_exp [4] = '{64'hFEDC_BA98_7654_3210, 64'h0FED_CBA9_8765_4321,
                                 64'h00FE_DCBA_9876_5432, 64'h000F_EDCB_A987_6543};

    always #5 clk = ~clk;

    snow64_pipelined_simd_shifter #(.WIDTH__DATA_INOUT(W), .NUM_PIPE_STAGES(NS)) dut (
        .clk(clk), .rst(rst), .in_flush(in_flush), .in_req_valid(in_req_valid),
        .out_req_ready(out_req_ready), .in_op(in_op), .in_size(in_size),
        .in_to_shift(in_to_shift), .in_amount(in_amount), .out_res_valid(out_res_valid),
        .in_res_ready(in_res_ready), .out_data(out_data)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] sz, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e, input bit push);
        int t = 0;
        in_req_valid = 1;
        in_op = op;
        in_size = sz;
        in_to_shift = a;
        in_amount = b;
        do begin
            @(negedge clk);
            t++;
        end while (!out_req_ready && t < 50);
        if (!out_req_ready) timeout("accept");
        else if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_req_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_res_valid && in_res_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected result: got %h expected none", out_data);
            end else chk("scoreboard", out_data, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(vec_t'{2'd2, 2'd0, 64'h0000_0000_807F_F001, 64'h0000_0000_0108_C800, 64'h0000_0000_C000_FF01});
        vecs.push_back(vec_t'{2'd1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0004_0010_0000_000F, 64'h0FFF_0000_FFFF_0001});
        vecs.push_back(vec_t'{2'd3, 2'd2, 64'h0000_0001_8000_0001, 64'h0000_0004_0000_0001, 64'h0000_0010_0000_0002});
        vecs.push_back(vec_t'{2'd2, 2'd3, 64'h8000_0000_0000_0000, 64'd64, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back(vec_t'{2'd2, 2'd2, 64'h8000_0000_7FFF_FFFF, 64'h0000_001F_0000_0004, 64'hFFFF_FFFF_07FF_FFFF});
        vecs.push_back(vec_t'{2'd0, 2'd0, 64'h0102_0408_1020_4080, 64'h0001_0203_0405_0607, 64'h0104_1040_0000_0000});
        vecs.push_back(vec_t'{2'd2, 2'd1, 64'h8000_7FFF_8001_0000, 64'h000F_000F_0001_0000, 64'hFFFF_0000_C000_0000});

        #23 rst = 0;
        @(negedge clk);
        chk("reset valid", W'(out_res_valid), 0);
        chk("reset ready", W'(out_req_ready), 1);
        chk("reset data", out_data, 0);
        @(posedge clk);
        #1;

        send(2'd0, 2'd3, 64'h1, 64'd63, 64'h8000_0000_0000_0000, 1);
        for (int i = 1; i <= NS; i++) begin
            @(negedge clk);
            chk("latency valid", W'(out_res_valid), W'(i == NS));
        end
        drain();

        foreach (vecs[i]) send(vecs[i].op, vecs[i].sz, vecs[i].a, vecs[i].b, vecs[i].e, 1);
        drain();

        fork
            for (int i = 0; i < 4; i++)
                send(2'd1, 2'd3, 64'hFEDC_BA98_7654_3210, W'(4 * i), bp_exp[i], 1);
            begin
                int t = 0;
                while (!out_res_valid && t < 50) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                if (!out_res_valid) timeout("first result");
                in_res_ready = 0;
                held = out_data;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall valid", W'(out_res_valid), 1);
                    chk("stall hold", out_data, held);
                    chk("stall ready", W'(out_req_ready), 0);
                    @(posedge clk);
                    #1;
                end
                in_res_ready = 1;
            end
        join
        drain();

        in_res_ready = 0;
        send(2'd0, 2'd3, 64'h1, 64'h1, 0, 0);
        send(2'd0, 2'd3, 64'h2, 64'h1, 0, 0);
        #3 rst = 1;
        #1;
        chk("async rst valid", W'(out_res_valid), 0);
        chk("async rst data", out_data, 0);
        #3 rst = 0;
        in_res_ready = 1;
        repeat (4) begin
            @(negedge clk);
            chk("post rst valid", W'(out_res_valid), 0);
        end
        @(posedge clk);
        #1;

        send(2'd0, 2'd3, 64'h5, 64'h4, 0, 0);
        in_flush = 1;
        in_req_valid = 1;
        in_to_shift = 64'h7;
        @(negedge clk);
        chk("flush ready", W'(out_req_ready), 0);
        @(posedge clk);
        #1;
        in_flush = 0;
        in_req_valid = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post flush valid", W'(out_res_valid), 0);
        end
        @(posedge clk);
        #1;
        send(2'd1, 2'd3, 64'hF0, 64'd4, 64'hF, 1);
        drain();

        chk("queue empty", W'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/snow64_pipelined_simd_shifter.md
# snow64_pipelined_simd_shifter

Parametrised, pipelined successor to the single-width combinational shifters: one unit performs logical-left, logical-right and arithmetic-right shifts on a packed vector of 8/16/32/64-bit lanes, with the lane size selected per request. The log2(width) shift levels are split across configurable register stages with valid/ready flow control on both sides. It sits in the ALU execute path beside the adder/SLT logic and drains into the writeback mux.

## Interface
- WIDTH__DATA_INOUT, 64: vector width; power of two, ≥ 64.
- NUM_PIPE_STAGES, 2: register stages; must divide $clog2(64) = 6, so legal values are 1, 2, 3 and 6.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all stage valids.
- in_flush  in  1  synchronous pipeline clear.
- in_req_valid  in  1  request present.
- out_req_ready  out  1  request accepted this cycle when high together with in_req_valid.
- in_op  in  2  PkgSnow64Shifter::ShiftOp: LSL=0, LSR=1, ASR=2; 3 is reserved and behaves as LSL.
- in_size  in  2  PkgSnow64Shifter::LaneSize: 8=0, 16=1, 32=2, 64=3.
- in_to_shift  in  WIDTH__DATA_INOUT  packed operand lanes.
- in_amount  in  WIDTH__DATA_INOUT  packed per-lane unsigned shift amounts.
- out_res_valid  out  1  result present.
- in_res_ready  in  1  downstream consumes the result when high together with out_res_valid.
- out_data  out  WIDTH__DATA_INOUT  packed result.

## Operation
- Lane width LW = 8 << in_size. Lanes are independent.
- Each lane's amount is that lane's full field of in_amount, unsigned.
- If a lane's amount ≥ LW:
  - LSL and LSR yield 0.
  - ASR yields LW copies of the lane MSB.
- Otherwise:
  - LSL zero-fills at the lane LSB.
  - LSR zero-fills at the lane MSB.
  - ASR fills with the lane's original MSB.
- Bits never cross lane boundaries.
- Level k (k = 0..5) conditionally shifts by 2^k. It is active only when 2^k < LW, so levels 3–5 are bypassed for 8-bit lanes.
- The overflow (amount ≥ LW) decision is computed in stage 0. It travels with the data and forces the final value at the last stage.
- Levels per stage = 6 / NUM_PIPE_STAGES, assigned in ascending order.
- Each stage holds data, op, size, overflow mask, original sign bits and a valid bit.
- Stage i loads when it is empty or stage i+1 loads. The last stage counts as loading when in_res_ready is high.
- out_req_ready = !in_flush && (stage 0 empty || stage 0 loads). It is combinational from in_res_ready; there is no skid buffer.
- in_flush clears every valid on the next edge. A request presented during a flush cycle is not accepted.
- While stalled (out_res_valid=1, in_res_ready=0), out_data and every stage are held unchanged.

## Timing
- Latency: accepted at edge N → out_res_valid high after edge N+NUM_PIPE_STAGES, when unstalled.
- Throughput: one result per cycle with no bubbles when in_res_ready stays high.
- Reset value: out_res_valid=0, out_req_ready=1 (unless in_flush is high), out_data=0. Data registers also reset to 0.
- Assertion of rst clears all valids immediately, without waiting for a clock edge. No partially shifted result emerges after release.
- Capacity: NUM_PIPE_STAGES requests in flight.
- With the pipeline full and in_res_ready=0, out_req_ready=0.

## Structure
- The package PkgSnow64Shifter holds:
  - the ShiftOp and LaneSize enums;
  - LOG2__WIDTH = 6 and the LANE_WIDTH(size) constant function;
  - the stage payload packed struct.
- One sub-module, snow64_simd_shift_level: a combinational single 2^k level across all lanes. It takes the level index as a parameter and op, size and sign bits as inputs. The top module instantiates 6 of them and registers the outputs at the stage boundaries.

## Test plan
- LSL, size=64, to_shift=0x1, amount=63 → out_data=0x8000_0000_0000_0000 exactly NUM_PIPE_STAGES cycles after acceptance.
- ASR, size=8, to_shift=0x0000_0000_807F_F001, amount=0x0000_0000_0108_C800 → 0x0000_0000_C000_FF01. This covers the overflow sign-fill lane (0xF0 → 0xFF) and the amount=LW zero lane (0x7F → 0x00).
- LSR, size=16, to_shift=0xFFFF_FFFF_FFFF_FFFF, amount=0x0004_0010_0000_000F → 0x0FFF_0000_FFFF_0001. This covers no lane bleed and amount=LW giving 0.
- Backpressure: 4 back-to-back requests, in_res_ready=0 for 5 cycles starting when the first result appears:
  - out_req_ready drops once NUM_PIPE_STAGES requests are held;
  - out_data is stable throughout the stall;
  - all results arrive in order with none lost or duplicated.
- Async rst asserted between clock edges with 2 requests in flight → out_res_valid=0 before the next edge, and no stale result after release.
- in_flush with in_req_valid=1 in the same cycle → out_req_ready=0, pipeline empty next cycle, and a subsequent request returns the correct result.
